// File: rtl/mfp_spi_ctrl_pkg.sv
// Shared definitions for the PmodALS SPI controller: frame geometry, FSM
// state encoding and the frame-error helper.
package mfp_spi_ctrl_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned DATA_MSB   = 11;
    localparam int unsigned DATA_LSB   = 4;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StQuietWait = 3'd1,
        StArm       = 3'd2,
        StShift     = 3'd3,
        StDone      = 3'd4
    } state_e;

    // The sensor pads the 8-bit result with zeros on both sides.
    function automatic logic frame_err_of(input logic [FRAME_BITS-1:0] w);
        return (|w[FRAME_BITS-1:DATA_MSB+1]) | (|w[DATA_LSB-1:0]);
    endfunction

endpackage

// File: rtl/mfp_spi_sck_gen.sv
// Free-running SCK divider. Ticks are asserted in the cycle whose closing
// edge drives SCK high (rise) or low (fall).
module mfp_spi_sck_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic sck_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);

    logic [7:0] cnt_q, cnt_d;
    logic       sck_q, sck_d;
    logic       wrap;

    assign wrap = (cnt_q == 8'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        sck_d = sck_q;
        if (wrap) begin
            cnt_d = 8'd0;
            sck_d = ~sck_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
            sck_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck_o       = sck_q;
    assign rise_tick_o = wrap & ~sck_q;
    assign fall_tick_o = wrap & sck_q;

endmodule

// File: rtl/mfp_pmod_als_spi_ctrl.sv
// SPI master for the PmodALS light sensor: paces frames with a CS-high quiet
// gap, shifts in 16 bits on SCK rises and publishes the 8-bit light value.
module mfp_pmod_als_spi_ctrl
    import mfp_spi_ctrl_pkg::*;
#(
    parameter int unsigned DIV   = 4,
    parameter int unsigned QUIET = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    input  logic        auto_en,
    output logic        busy,
    output logic        valid,
    output logic [7:0]  data,
    output logic [15:0] raw,
    output logic        frame_err,
    output logic        SPI_CS,
    output logic        SPI_SCK,
    input  logic        SPI_SDO
);

    localparam logic [3:0] QuietCnt = 4'(QUIET);

    logic rise_tick, fall_tick;

    mfp_spi_sck_gen #(
        .DIV(DIV)
    ) u_sck_gen (
        .clk_i      (HCLK),
        .rst_ni     (HRESETn),
        .sck_o      (SPI_SCK),
        .rise_tick_o(rise_tick),
        .fall_tick_o(fall_tick)
    );

    state_e                  state_q;
    logic                    cs_q;
    logic                    busy_q;
    logic                    valid_q;
    logic [FRAME_BITS-1:0]   shift_q;
    logic [FRAME_BITS-1:0]   raw_q;
    logic [7:0]              data_q;
    logic                    err_q;
    logic [4:0]              bit_cnt_q;
    logic                    seen_fall_q;
    logic [3:0]              quiet_cnt_q, quiet_cnt_d;

    // Counts falling SCK edges seen with CS high; saturates so idle time is credited.
    always_comb begin
        quiet_cnt_d = quiet_cnt_q;
        if (!cs_q) begin
            quiet_cnt_d = 4'd0;
        end else if (fall_tick && (quiet_cnt_q < QuietCnt)) begin
            quiet_cnt_d = quiet_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            quiet_cnt_q <= 4'd0;
        end else begin
            quiet_cnt_q <= quiet_cnt_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q     <= StIdle;
            cs_q        <= 1'b1;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            shift_q     <= '0;
            raw_q       <= '0;
            data_q      <= 8'd0;
            err_q       <= 1'b0;
            bit_cnt_q   <= 5'd0;
            seen_fall_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A start landing on the valid pulse is dropped.
                    if ((start && !valid_q) || auto_en) begin
                        state_q <= StQuietWait;
                        busy_q  <= 1'b1;
                    end
                end
                StQuietWait: begin
                    busy_q <= 1'b1;
                    if (quiet_cnt_q >= QuietCnt) begin
                        state_q <= StArm;
                    end
                end
                StArm: begin
                    if (rise_tick) begin
                        cs_q        <= 1'b0;
                        bit_cnt_q   <= 5'd0;
                        seen_fall_q <= 1'b0;
                        state_q     <= StShift;
                    end
                end
                StShift: begin
                    if (fall_tick) begin
                        seen_fall_q <= 1'b1;
                    end
                    if (rise_tick && seen_fall_q) begin
                        shift_q   <= {shift_q[FRAME_BITS-2:0], SPI_SDO};
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'(FRAME_BITS - 1)) begin
                            cs_q    <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    raw_q   <= shift_q;
                    data_q  <= shift_q[DATA_MSB:DATA_LSB];
                    err_q   <= frame_err_of(shift_q);
                    state_q <= auto_en ? StQuietWait : StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign data      = data_q;
    assign raw       = raw_q;
    assign frame_err = err_q;
    assign SPI_CS    = cs_q;

endmodule

// File: doc/mfp_pmod_als_spi_ctrl.md
MFP_PMOD_ALS_SPI_CTRL -- requirements
Module: mfp_pmod_als_spi_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning HCLK cycles per SCK half-period (legal range 2..255).
REQ-002 SHALL have parameter QUIET, default 1, meaning the minimum number of full SCK periods with CS high between frames (legal range 1..15).
REQ-003 SHALL have port HCLK, input, 1 bit: the single clock; one clock; all logic on its rising edge.
REQ-004 SHALL have port HRESETn, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request for a single conversion.
REQ-006 SHALL have port auto_en, input, 1 bit: level; when high, frames repeat back-to-back.
REQ-007 SHALL have port busy, output, 1 bit: high from request acceptance until the cycle valid pulses.
REQ-008 SHALL have port valid, output, 1 bit: one-cycle pulse when data, raw and frame_err update.
REQ-009 SHALL have port data, output, 8 bits: light value, equal to raw[11:4].
REQ-010 SHALL have port raw, output, 16 bits: full received frame, MSB first.
REQ-011 SHALL have port frame_err, output, 1 bit: high when raw[15:12] or raw[3:0] is nonzero.
REQ-012 SHALL have port SPI_CS, output, 1 bit: active-low chip select.
REQ-013 SHALL have port SPI_SCK, output, 1 bit: serial clock, idles high.
REQ-014 SHALL have port SPI_SDO, input, 1 bit: serial data from the sensor.

Function
REQ-015 SPI_SCK SHALL free-run whenever out of reset, toggling every DIV HCLK cycles, so the sensor reloads its shift buffer on falling edges while CS is high.
REQ-016 The SCK generator SHALL emit rise_tick or fall_tick in the HCLK cycle in which it drives SPI_SCK high or low respectively.
REQ-017 The FSM SHALL have states IDLE, QUIET_WAIT, ARM, SHIFT and DONE.
REQ-018 IDLE -> QUIET_WAIT on start=1 or auto_en=1; busy SHALL rise in the following cycle.
REQ-019 QUIET_WAIT SHALL count QUIET fall_ticks with SPI_CS high since the end of the last frame (or since reset), then move to ARM; the fall_ticks already counted during IDLE SHALL be credited.
REQ-020 ARM SHALL drive SPI_CS low in the same cycle as the next rise_tick and enter SHIFT with bit counter = 0.
REQ-021 SHIFT SHALL, on each rise_tick after the first fall_tick, shift SPI_SDO into raw_shift[0] (left shift) and increment the bit counter.
REQ-022 On the 16th sample, SPI_CS SHALL go high in that same cycle and the FSM SHALL enter DONE.
REQ-023 DONE SHALL last one cycle: it pulses valid, registers raw, data and frame_err, and drops busy.
REQ-024 DONE -> QUIET_WAIT if auto_en=1, else -> IDLE.
REQ-025 start SHALL be ignored while busy=1; a start coincident with the valid pulse SHALL also be ignored.
REQ-026 Deasserting auto_en mid-frame SHALL let the current frame complete; no further frame SHALL start.
REQ-027 data, raw and frame_err SHALL hold their values between valid pulses.
REQ-028 Start-to-valid latency SHALL be at most 2*DIV*(QUIET+18)+4 HCLK cycles.

Reset
REQ-029 While HRESETn=0 at a clock edge, the next state SHALL be: FSM=IDLE, SPI_CS=1, SPI_SCK=1, divider count=0, busy=0, valid=0, data=0, raw=0, frame_err=0, quiet count=0.
REQ-030 A reset in mid-frame SHALL abort the frame with no valid pulse; SPI_CS SHALL be high and SPI_SCK high in the first cycle after reset.

Structure
REQ-031 A shared package mfp_spi_ctrl_pkg SHALL hold the FSM state encoding, FRAME_BITS=16, DATA_MSB=11 and DATA_LSB=4.
REQ-032 The SCK divider and tick generator SHALL be a separate sub-module, mfp_spi_sck_gen.

Verification
REQ-033 Scenario 1: DIV=4, sensor stub value 8'hAB, single start -> exactly 16 SCK rising edges with SPI_CS low; raw=16'h0AB0, data=8'hAB, frame_err=0; one valid pulse.
REQ-034 Scenario 2: bench-driven SDO pattern 16'hF123 -> raw=16'hF123, data=8'h12, frame_err=1.
REQ-035 Scenario 3: second start pulse issued 10 cycles after the first -> only one frame and one valid pulse.
REQ-036 Scenario 4: auto_en=1 for 3 frames, QUIET=1 -> 3 valid pulses, each data=8'hAB; SPI_CS high for at least 2*DIV cycles, including at least one SCK falling edge, between frames.
REQ-037 Scenario 5: HRESETn low for one cycle after the 7th sampled bit -> next cycle SPI_CS=1, SPI_SCK=1, busy=0, no valid; a following start yields data=8'hAB.
REQ-038 Scenario 6: DIV=2 -> SCK period 4 HCLK; latency within REQ-028 bound; data=8'hAB.
